// File: rtl/tape_pkg.sv
// Shared types and defaults for the tape playback fetch engine.
//   state_t    : fetch state machine encoding (idle, read outstanding, aborting read)
//   TAPE_AW    : default SDRAM tape address width
//   TAPE_DEPTH : default prefetch FIFO depth in bytes
package tape_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_ABORT = 2'd2
  } state_t;

  localparam int TAPE_AW    = 23;
  localparam int TAPE_DEPTH = 4;

endpackage

// File: rtl/tape_fifo.sv
// Byte-wide synchronous prefetch FIFO with flush.
//   clk_sys, reset_n : system clock, asynchronous active-low reset
//   flush            : empties the FIFO; takes priority over push and pop
//   push, push_data  : write one byte (ignored when full unless popping too)
//   pop              : remove the head byte (ignored when empty)
//   head             : current head byte (combinational read)
//   level            : number of bytes held, 0..DEPTH
module tape_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (level != '0);
  // A full FIFO can still accept a byte when the head leaves on the same edge.
  assign do_push = push && ((level != FULL) || do_pop);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only the pointers and level define contents.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/tape_stream_fetch.sv
// Tape playback fetch engine: streams a downloaded tape image from SDRAM
// through a prefetch FIFO and serves it byte by byte to the TZX player.
//   clk_sys, reset_n   : system clock, asynchronous active-low reset
//   dl_active, dl_addr : tape download in progress and current byte address
//   restart            : one-cycle rewind request
//   mem_addr, mem_rd   : SDRAM read address and held read request
//   mem_ack, mem_data  : toggle acknowledge and read data from SDRAM
//   tzx_req, tzx_ack   : player toggle handshake
//   tzx_data           : byte served to the player
//   tape_reset         : player restart (download in progress or rewind)
//   eot                : whole image delivered and buffer drained
//   level              : prefetch FIFO occupancy
module tape_stream_fetch
  import tape_pkg::*;
#(
  parameter int AW    = TAPE_AW,
  parameter int DEPTH = TAPE_DEPTH,
  parameter int BASE  = 0
) (
  input  logic                         clk_sys,
  input  logic                         reset_n,
  input  logic                         dl_active,
  input  logic [AW-1:0]                dl_addr,
  input  logic                         restart,
  output logic [AW-1:0]                mem_addr,
  output logic                         mem_rd,
  input  logic                         mem_ack,
  input  logic [7:0]                   mem_data,
  input  logic                         tzx_req,
  output logic                         tzx_ack,
  output logic [7:0]                   tzx_data,
  output logic                         tape_reset,
  output logic                         eot,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  state_t        state;
  logic [AW-1:0] play_addr;
  logic [AW-1:0] last_addr;
  logic          loaded;
  logic          ack_q;

  logic          flush;
  logic          ack_edge;
  logic          issue;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // Download and rewind both empty the buffer and restart from the top.
  assign flush    = dl_active | restart;
  assign ack_edge = (mem_ack != ack_q);
  // Only checked in S_IDLE, where no byte is in flight, so level < DEPTH
  // already accounts for the outstanding read.
  assign issue    = (state == S_IDLE) && loaded && !flush &&
                    (play_addr <= last_addr) && (level < FULL);
  // A flush on the ack edge discards the returning byte.
  assign push     = (state == S_REQ) && ack_edge && !flush;
  assign pop      = (tzx_req != tzx_ack) && (level != '0) && !flush;
  assign mem_addr = AW'(BASE) + play_addr;
  assign eot      = loaded && (play_addr > last_addr) && (level == '0) &&
                    (state == S_IDLE);

  tape_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (push),
    .push_data (mem_data),
    .pop       (pop),
    .head      (head),
    .level     (level)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      mem_rd     <= 1'b0;
      play_addr  <= '0;
      last_addr  <= '0;
      loaded     <= 1'b0;
      ack_q      <= 1'b0;
      tzx_ack    <= 1'b0;
      tzx_data   <= 8'h00;
      tape_reset <= 1'b1;
    end else begin
      // Tracking the ack level in every state lets a stale toggle after
      // reset or abort be absorbed without being treated as a completion.
      ack_q      <= mem_ack;
      tape_reset <= flush;

      if (pop) begin
        tzx_data <= head;
        tzx_ack  <= tzx_req;
      end

      if (dl_active) begin
        last_addr <= dl_addr;
        loaded    <= 1'b1;
      end

      if (flush)     play_addr <= '0;
      else if (push) play_addr <= play_addr + AW'(1);

      case (state)
        S_IDLE: begin
          if (issue) begin
            mem_rd <= 1'b1;
            state  <= S_REQ;
          end
        end
        S_REQ: begin
          if (ack_edge) begin
            mem_rd <= 1'b0;
            state  <= S_IDLE;
          end else if (flush) begin
            // The read cannot be cancelled at the SDRAM; wait it out.
            state <= S_ABORT;
          end
        end
        S_ABORT: begin
          if (ack_edge) begin
            mem_rd <= 1'b0;
            state  <= S_IDLE;
          end
        end
        default: begin
          mem_rd <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/tape_stream_fetch.md
# tape_stream_fetch

Parametrised tape-playback fetch engine between the SDRAM tape port and the TZX player. Successor to the inline single-byte fetch loop: records the extent of a downloaded tape image, streams it from SDRAM through a prefetch FIFO of configurable depth, and serves bytes to the player over a toggle handshake. Adds restart/rewind with abort of an in-flight read, an end-of-tape flag, and buffer-level reporting.

## Interface
- AW, 23: SDRAM tape address width.
- DEPTH, 4: prefetch FIFO depth in bytes, power of two, ≥2.
- BASE, 0: first SDRAM byte address of the tape image.
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- dl_active  in  1  tape download in progress.
- dl_addr  in  AW  byte address being written by the download, relative to BASE.
- restart  in  1  one-cycle rewind request.
- mem_addr  out  AW  SDRAM read address.
- mem_rd  out  1  read request level, held until acknowledged.
- mem_ack  in  1  SDRAM acknowledge, toggles once per completed read.
- mem_data  in  8  read data, valid when mem_ack toggles.
- tzx_req  in  1  player request, toggles once per byte wanted.
- tzx_ack  out  1  toggles to equal tzx_req when tzx_data is valid.
- tzx_data  out  8  byte to player.
- tape_reset  out  1  player restart pulse.
- eot  out  1  image fully delivered.
- level  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- Registers: play_addr (AW), last_addr (AW), loaded, ack_q, FIFO, state.
- Download: while dl_active, last_addr <= dl_addr, play_addr <= 0, FIFO flushed, loaded <= 1, tape_reset = 1. No fetch is issued while dl_active.
- mem_addr = BASE + play_addr, AW-bit wrap.
- State machine:
  - S_IDLE: issue a fetch when loaded, !dl_active, play_addr <= last_addr, and level < DEPTH. Then mem_rd <= 1 and go to S_REQ.
  - S_REQ: on ack edge (mem_ack != ack_q), push mem_data, play_addr++, mem_rd <= 0, go to S_IDLE.
  - S_ABORT: entered from S_REQ on restart or dl_active rise. Wait for the ack edge, discard the data, mem_rd <= 0, go to S_IDLE.
- ack_q <= mem_ack every cycle.
- Restart in S_IDLE or S_ABORT: flush FIFO, play_addr <= 0, tape_reset pulse 1 cycle. In S_REQ the same applies and the state goes to S_ABORT.
- Player service: when tzx_req != tzx_ack and level > 0, tzx_data <= FIFO head, pop, tzx_ack <= tzx_req. Requests with FIFO empty stay pending, with no timeout.
- Push and pop may occur in the same cycle; level is unchanged.
- A flush in the same cycle as a push or pop wins: level becomes 0 and a pending player request is not served.
- eot = loaded & (play_addr > last_addr) & (level == 0) & state==S_IDLE.

## Timing
- Reset values: mem_rd 0, mem_addr BASE, tzx_ack 0, tzx_data 0, tape_reset 1, eot 0, level 0, state S_IDLE, loaded 0.
- tape_reset deasserts on the first clock after reset_n rises.
- mem_rd rises 1 cycle after the issue condition becomes true.
- The ack edge is detected at the first clk_sys edge where mem_ack differs from ack_q. Push and mem_rd fall occur on that edge.
- The next mem_rd can rise on the following cycle, giving at most one read per 2 cycles plus SDRAM latency.
- tzx_ack and tzx_data update on the same edge, 1 cycle after tzx_req toggles when level > 0.
- At most one outstanding SDRAM read at any time. The FIFO-full check counts the in-flight byte, so level never exceeds DEPTH.
- Reset mid-read: all state cleared. A late mem_ack toggle after reset only resynchronises ack_q and is not pushed.

## Structure
- Package tape_pkg:
  - state enum: S_IDLE, S_REQ, S_ABORT.
  - default constants: TAPE_AW=23, TAPE_DEPTH=4.
- Sub-module tape_fifo:
  - DEPTH×8 synchronous FIFO with flush, push, pop, head and level outputs.
  - Push and pop in the same cycle are legal.
  - Same clock and reset as the parent.

## Test plan
- Download of dl_addr 0..9, then player requests 10 bytes (memory model returns addr^8'h5A, 3-cycle ack) -> tzx_data sequence 5A,5B,…,53; eot=1 after the 10th ack; no mem_rd after play_addr reaches 10.
- Player idle, DEPTH=4 -> exactly 4 reads issued, level=4, mem_rd stays 0.
- restart asserted while mem_rd=1 (ack delayed 5 cycles) -> acked byte discarded, level=0, tape_reset 1-cycle pulse, next mem_addr=BASE.
- Simultaneous push and pop at level=2 -> level stays 2 and byte order is preserved.
- dl_active rising during playback -> FIFO flushed, eot=0, no reads until dl_active falls, last_addr equals the final dl_addr.
- reset_n low mid-S_REQ, then a stale mem_ack toggle -> no push, level 0, all outputs at reset values.
